spike_event_logger: RTL and testbench

Downstream consumer of the HH neuron pair's spike outputs (neuron 1 and neuron 2 spike bits).
- Detects spike rising edges and timestamps them with a free-running cycle counter.
- Buffers the events in a small FIFO.
- Presents them on a valid/ready stream, so a host or readout stage can reconstruct spike trains and STDP timing offline without sampling every cycle.

---
 rtl/spike_log_pkg.sv | 30 +++
 rtl/spike_event_logger_fifo.sv | 85 ++++++++
 rtl/spike_event_logger.sv | 106 ++++++++++
 tb/tb_spike_event_logger.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_log_pkg.sv
// Shared defaults, event-word layout and helpers for the spike event logger.
package spike_log_pkg;

   // Default instance geometry
   localparam int unsigned TS_W_DEF  = 16;
   localparam int unsigned NCH_DEF   = 2;
   localparam int unsigned DEPTH_DEF = 8;

   // Event word layout: {mask, ts}, timestamp in the low bits
   localparam int unsigned TS_LSB    = 0;
   localparam int unsigned MASK_LSB  = TS_W_DEF;

   // An all-zero mask with an all-ones timestamp marks an epoch boundary
   localparam logic [NCH_DEF-1:0] WRAP_MASK = '0;

   // Width of the saturating overflow counter
   localparam int unsigned DROP_W    = 8;

   // Increment that sticks at the maximum value instead of rolling over
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      logic [DROP_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + DROP_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/spike_event_logger_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with synchronous flush.
// Head word is presented combinationally from storage; zero when empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic                   o_valid,
   output logic                   o_full,
   output logic [WIDTH-1:0]       o_data,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Pointer arithmetic relies on natural wrap, so depth must be 2^n
   if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   // Handshake qualification: a pop frees a slot for a same-cycle push when full
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == FULL_CNT);
      w_do_pop  = i_pop & ~w_empty & ~i_flush;
      w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;
   end

   // Storage write; left unreset since the head is masked while empty
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy update; flush wins over any transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

   // Show-ahead outputs
   always_comb begin
      o_valid = ~w_empty;
      o_full  = w_full;
      o_count = r_count;
      o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   end

endmodule

// File: rtl/spike_event_logger.sv
// spike_event_logger: timestamps rising edges on NCH spike lines, emits
// end-of-epoch markers on counter wrap, and queues {mask, ts} words on a
// valid/ready stream. Overflowing events are counted, not stored.
module spike_event_logger
   import spike_log_pkg::*;
#(
   parameter int unsigned TS_W  = TS_W_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned NCH   = NCH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   clear,
   input  logic [NCH-1:0]         spike_in,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [NCH+TS_W-1:0]    evt_data,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [DROP_W-1:0]      drop_count
);

   localparam int unsigned EW           = NCH + TS_W;
   localparam int unsigned EVT_MASK_LSB = TS_LSB + TS_W;

   logic [NCH-1:0]    r_spike_prev;
   logic [TS_W-1:0]   r_ts;
   logic [DROP_W-1:0] r_drop;

   logic [NCH-1:0]    w_rise;
   logic              w_any_rise;
   logic              w_wrap;
   logic              w_log;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_drop;
   logic [EW-1:0]     w_push_word;

   // Edge history follows the input every cycle so re-enabling cannot fake edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spike_prev <= '0;
      end else begin
         r_spike_prev <= spike_in;
      end
   end

   // Free-running timestamp, paused by ena, zeroed by clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts <= '0;
      end else if (clear) begin
         r_ts <= '0;
      end else if (ena) begin
         r_ts <= r_ts + TS_W'(1);
      end
   end

   // Event mux: spike words take precedence; the wrap cycle alone yields a marker
   always_comb begin
      w_rise      = spike_in & ~r_spike_prev;
      w_any_rise  = |w_rise;
      w_wrap      = &r_ts;
      w_log       = ena & ~clear;
      w_push      = w_log & (w_any_rise | w_wrap);
      w_pop       = evt_valid & evt_ready;
      w_drop      = w_push & w_full & ~w_pop;
      w_push_word = '0;
      w_push_word[TS_LSB +: TS_W] = r_ts;
      w_push_word[EVT_MASK_LSB +: NCH] = w_any_rise ? w_rise : NCH'(WRAP_MASK);
   end

   // Saturating count of events lost to a full queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop <= '0;
      end else if (clear) begin
         r_drop <= '0;
      end else if (w_drop) begin
         r_drop <= sat_inc(r_drop);
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (clear),
      .i_push  (w_push),
      .i_data  (w_push_word),
      .i_pop   (evt_ready),
      .o_valid (evt_valid),
      .o_full  (w_full),
      .o_data  (evt_data),
      .o_count (fifo_count)
   );

   // Drive the drop counter output
   always_comb begin
      drop_count = r_drop;
   end

endmodule

// File: tb/tb_spike_event_logger.sv
// Scoreboard bench for spike_event_logger: stimulus pushes expected words,
// per-DUT monitors pop and compare on every accepted handshake.
module tb_spike_event_logger;

   logic        clk;
   logic        rst_n;

   // Main instance, 16-bit timestamp
   logic        ena;
   logic        clear;
   logic [1:0]  spike_in;
   logic        evt_ready;
   logic        evt_valid;
   logic [17:0] evt_data;
   logic [3:0]  fifo_count;
   logic [7:0]  drop_count;

   // Narrow instance, 4-bit timestamp for the wrap marker
   logic        ena_b;
   logic        clear_b;
   logic [1:0]  spike_b;
   logic        ready_b;
   logic        valid_b;
   logic [5:0]  data_b;
   logic [3:0]  count_b;
   logic [7:0]  drop_b;

   int          n_tests;
   int          n_fail;
   logic [17:0] exp_q [$];
   logic [5:0]  exp_qb [$];
   logic [15:0] ts_m;

   spike_event_logger #(
      .TS_W  (16),
      .DEPTH (8),
      .NCH   (2)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .clear      (clear),
      .spike_in   (spike_in),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_data   (evt_data),
      .fifo_count (fifo_count),
      .drop_count (drop_count)
   );

   spike_event_logger #(
      .TS_W  (4),
      .DEPTH (8),
      .NCH   (2)
   ) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena_b),
      .clear      (clear_b),
      .spike_in   (spike_b),
      .evt_valid  (valid_b),
      .evt_ready  (ready_b),
      .evt_data   (data_b),
      .fifo_count (count_b),
      .drop_count (drop_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference timestamp for the main instance
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_m <= '0;
      end else if (clear) begin
         ts_m <= '0;
      end else if (ena) begin
         ts_m <= ts_m + 16'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for the main instance
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL evt_a: got 0x%0h, expected no word", evt_data);
         end else begin
            check("evt_a", 32'(evt_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // Monitor for the narrow instance
   always @(negedge clk) begin
      if (rst_n && valid_b && ready_b) begin
         if (exp_qb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL evt_b: got 0x%0h, expected no word", data_b);
         end else begin
            check("evt_b", 32'(data_b), 32'(exp_qb.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ts(input logic [15:0] v);
      for (int i = 0; i < 200; i++) begin
         if (ts_m == v) break;
         tick(1);
      end
      if (ts_m != v) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_ts: got %0d, expected %0d", ts_m, v);
      end
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 40; i++) begin
         if (fifo_count == 4'd0) break;
         tick(1);
      end
      check(name, 32'(fifo_count), 32'd0);
   endtask

   // One-cycle pulse; the event carries the timestamp seen at the capturing edge
   task automatic pulse_spike(input logic [1:0] m, input bit stored);
      spike_in = m;
      if (stored) exp_q.push_back({m, ts_m});
      tick(1);
      spike_in = 2'b00;
      tick(1);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      ena       = 1'b0;
      clear     = 1'b0;
      spike_in  = 2'b00;
      evt_ready = 1'b0;
      ena_b     = 1'b0;
      clear_b   = 1'b0;
      spike_b   = 2'b00;
      ready_b   = 1'b0;

      // Reset state
      #12;
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_data", 32'(evt_data), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      tick(1);
      rst_n = 1'b1;
      ena   = 1'b1;

      // Single-channel event at ts=5, then held high for 20 cycles
      wait_ts(16'd5);
      spike_in = 2'b01;
      exp_q.push_back({2'b01, 16'd5});
      @(negedge clk);
      check("t1_pre_valid", 32'(evt_valid), 32'd0);
      tick(1);
      @(negedge clk);
      check("t1_valid", 32'(evt_valid), 32'd1);
      check("t1_data", 32'(evt_data), 32'h1_0005);
      check("t1_count", 32'(fifo_count), 32'd1);
      tick(1);
      evt_ready = 1'b1;
      tick(18);
      spike_in = 2'b00;
      tick(2);
      check("t2_held_count", 32'(fifo_count), 32'd0);
      check("t2_held_q", 32'(exp_q.size()), 32'd0);

      // Coincident rise at ts=10, then staggered channel rises
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      wait_ts(16'd10);
      spike_in = 2'b11;
      exp_q.push_back({2'b11, 16'd10});
      tick(1);
      spike_in = 2'b00;
      tick(1);
      spike_in = 2'b01;
      exp_q.push_back({2'b01, ts_m});
      tick(1);
      spike_in = 2'b11;
      exp_q.push_back({2'b10, ts_m});
      tick(1);
      spike_in = 2'b00;
      tick(1);
      wait_empty("t2_drain");

      // Overflow: 11 events into 8 slots, then in-order drain
      evt_ready = 1'b0;
      for (int i = 0; i < 11; i++) begin
         pulse_spike((i % 2 == 0) ? 2'b01 : 2'b10, i < 8);
      end
      @(negedge clk);
      check("t3_count", 32'(fifo_count), 32'd8);
      check("t3_drop", 32'(drop_count), 32'd3);
      check("t3_valid", 32'(evt_valid), 32'd1);
      check("t3_head", 32'(evt_data), 32'(exp_q[0]));
      tick(1);
      evt_ready = 1'b1;
      wait_empty("t3_drain");
      @(negedge clk);
      check("t3_empty_valid", 32'(evt_valid), 32'd0);
      check("t3_empty_data", 32'(evt_data), 32'd0);
      check("t3_q", 32'(exp_q.size()), 32'd0);
      tick(1);

      // Push and pop in the same cycle while full
      evt_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pulse_spike(2'b01, 1'b1);
      end
      @(negedge clk);
      check("t4_full", 32'(fifo_count), 32'd8);
      tick(1);
      evt_ready = 1'b1;
      spike_in  = 2'b10;
      exp_q.push_back({2'b10, ts_m});
      tick(1);
      evt_ready = 1'b0;
      spike_in  = 2'b00;
      @(negedge clk);
      check("t4_count", 32'(fifo_count), 32'd8);
      check("t4_drop", 32'(drop_count), 32'd3);
      tick(1);
      evt_ready = 1'b1;
      wait_empty("t4_drain");
      check("t4_q", 32'(exp_q.size()), 32'd0);

      // Wrap marker on the 4-bit instance, then a spike in the wrap cycle
      clear_b = 1'b1;
      ena_b   = 1'b1;
      tick(1);
      clear_b = 1'b0;
      tick(15);
      @(negedge clk);
      check("t5_pre_marker", 32'(valid_b), 32'd0);
      exp_qb.push_back(6'b00_1111);
      tick(1);
      @(negedge clk);
      check("t5_marker_valid", 32'(valid_b), 32'd1);
      check("t5_marker_data", 32'(data_b), 32'h0F);
      check("t5_marker_count", 32'(count_b), 32'd1);
      tick(15);
      spike_b = 2'b10;
      exp_qb.push_back(6'b10_1111);
      tick(1);
      spike_b = 2'b00;
      @(negedge clk);
      check("t5_wrap_spike_count", 32'(count_b), 32'd2);
      tick(1);
      ready_b = 1'b1;
      tick(4);
      ena_b = 1'b0;
      @(negedge clk);
      check("t5_drained", 32'(count_b), 32'd0);
      check("t5_q", 32'(exp_qb.size()), 32'd0);
      tick(1);

      // Clear with 5 words held; a rise during clear is swallowed
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pulse_spike(2'b01, 1'b1);
      end
      @(negedge clk);
      check("t6_count5", 32'(fifo_count), 32'd5);
      check("t6_drop_pre", 32'(drop_count), 32'd3);
      tick(1);
      clear    = 1'b1;
      spike_in = 2'b10;
      exp_q.delete();
      tick(1);
      clear    = 1'b0;
      spike_in = 2'b11;
      exp_q.push_back({2'b01, 16'd0});
      @(negedge clk);
      check("t6_clr_count", 32'(fifo_count), 32'd0);
      check("t6_clr_drop", 32'(drop_count), 32'd0);
      check("t6_clr_valid", 32'(evt_valid), 32'd0);
      check("t6_clr_data", 32'(evt_data), 32'd0);
      tick(1);
      spike_in = 2'b00;
      @(negedge clk);
      check("t6_ts0_data", 32'(evt_data), 32'h1_0000);
      check("t6_ts0_count", 32'(fifo_count), 32'd1);
      tick(1);

      // Logging paused: no new words, queue still drains
      ena       = 1'b0;
      evt_ready = 1'b1;
      pulse_spike(2'b10, 1'b0);
      wait_empty("t6_paused_drain");
      ena = 1'b1;
      tick(1);

      // Asynchronous reset mid-operation
      evt_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         pulse_spike(2'b10, i < 8);
      end
      @(negedge clk);
      check("t6_pre_rst_drop", 32'(drop_count), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(evt_valid), 32'd0);
      check("t6_rst_data", 32'(evt_data), 32'd0);
      check("t6_rst_count", 32'(fifo_count), 32'd0);
      check("t6_rst_drop", 32'(drop_count), 32'd0);
      exp_q.delete();

      // Spike held across reset release counts once at ts=0
      spike_in = 2'b01;
      tick(2);
      #1;
      rst_n = 1'b1;
      exp_q.push_back({2'b01, 16'd0});
      @(negedge clk);
      check("t6_rel_valid_pre", 32'(evt_valid), 32'd0);
      tick(1);
      @(negedge clk);
      check("t6_rel_valid", 32'(evt_valid), 32'd1);
      check("t6_rel_data", 32'(evt_data), 32'h1_0000);
      check("t6_rel_count", 32'(fifo_count), 32'd1);
      tick(1);
      evt_ready = 1'b1;
      tick(6);
      spike_in = 2'b00;
      wait_empty("t6_rel_drain");

      check("end_q_a", 32'(exp_q.size()), 32'd0);
      check("end_q_b", 32'(exp_qb.size()), 32'd0);
      check("end_drop_b", 32'(drop_b), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
